uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of message requesters (2..8).
REQ-002 Parameter STALL_LIMIT, default 1023, idle cycles tolerated mid-message before the grant is revoked.
REQ-003 clk  input  1  system clock (27 MHz).
REQ-004 reset  input  1  reset; one clock; asynchronous, active-high.
REQ-005 req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 req_last  input  NUM_REQ  marks the final byte of a message.
REQ-008 req_ready  output  NUM_REQ  per-requester byte accepted.
REQ-009 tx_valid  output  1  byte offered to the UART byte transmitter.
REQ-010 tx_data  output  8  byte to the transmitter.
REQ-011 tx_ready  input  1  transmitter accepts the byte this cycle.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the current or last owner.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 stall_abort  output  1  one-cycle pulse on a STALL_LIMIT revocation.

Function
REQ-015 The FSM SHALL have states IDLE, TAG, XFER, and a handshake SHALL mean valid and ready both high on a rising clk edge.
REQ-016 In IDLE with any req_valid high, the arbiter SHALL pick round-robin: the first asserted index after grant_id (wrapping NUM_REQ-1 to 0), register it into grant_id, and leave IDLE on the next edge.
REQ-017 Arbitration latency SHALL be exactly one cycle from req_valid in IDLE to tx_valid high; an IDLE cycle with no request SHALL keep grant_id unchanged.
REQ-018 In XFER: tx_valid = req_valid[grant_id], tx_data = req_data[grant_id], and req_ready[grant_id] = tx_ready, all combinational; every other req_ready bit SHALL be 0.
REQ-019 Ownership SHALL be held for a whole message; a handshake with req_last[grant_id] high SHALL return to IDLE on the same edge.
REQ-020 IDLE SHALL drive tx_valid=0 and req_ready=0, so there is no back-to-back message without an IDLE cycle; fairness means requester i waits at most NUM_REQ-1 messages.
REQ-021 A 10-bit stall counter SHALL clear on entering XFER and on each handshake, and increment on every XFER cycle without a handshake.
REQ-022 When the stall counter equals STALL_LIMIT, the FSM SHALL go to IDLE, pulse stall_abort for one cycle and drop no owed handshake; the requester's remaining bytes are then treated as a new message.
REQ-023 req_valid deasserting mid-message SHALL NOT release the grant (only req_last or stall does).
REQ-024 tx_ready high while tx_valid is low SHALL have no effect.

Reset
REQ-025 Reset SHALL force IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, stall_abort=0, stall counter=0, and grant_id=NUM_REQ-1 so that requester 0 has first priority.
REQ-026 Reset asserted mid-message SHALL abort it immediately with no further handshake, and the first message after release SHALL be arbitrated afresh.

Configuration
REQ-027 With UART_ARB_TAG_EN defined: after arbitration the FSM SHALL enter TAG, present tx_data = 8'h41+grant_id ("A", "B", ...) with tx_valid=1 and all req_ready=0, then enter XFER on the tag handshake.
REQ-028 The stall counter SHALL NOT run in TAG.
REQ-029 Without UART_ARB_TAG_EN, state TAG SHALL not exist, arbitration SHALL go directly to XFER, and the byte stream SHALL be bit-identical to the requesters' data.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the FSM state encoding, the tag base constant 8'h41 and the default NUM_REQ/STALL_LIMIT values.
REQ-031 The round-robin pick SHALL be the sub-module rr_pick: combinational, with inputs request vector and last grant, and output the next index plus a found flag.

Verification
REQ-032 After reset, req_valid=4'b1111, tx_ready=1, each requester sending 2 bytes with last on the second -> grant order 0,1,2,3,0, one IDLE cycle between messages.
REQ-033 Requester 2 sends "Hi\r\n" while tx_ready toggles 1,0,1,0 -> tx_data sequence exactly 48 69 0D 0A, no duplicate or loss, req_ready[2] mirrors tx_ready.
REQ-034 Requester 1 is granted, sends 1 byte, then holds req_valid=0 for 1023 cycles -> stall_abort pulses once, busy=0 next cycle, a pending requester 3 is granted after.
REQ-035 Reset asserted during byte 3 of a 5-byte message from requester 0 -> outputs hit the reset values asynchronously, next grant goes to the lowest asserted index.
REQ-036 UART_ARB_TAG_EN defined, requester 1 sends "ok" with last -> tx_data 42 6F 6B; same test without the macro -> 6F 6B.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX message arbiter.
// The optional tag byte is built in when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_STALL_LIMIT = 1023;
  localparam int STALL_W         = 10;

  // Tag byte for requester i is TAG_BASE + i, i.e. "A", "B", ...
  localparam logic [7:0] TAG_BASE = 8'h41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_e;

  function automatic logic [7:0] tag_byte(input logic [7:0] id);
    return TAG_BASE + id;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after
// last_idx, wrapping from NUM_REQ-1 to 0; last_idx itself is checked last.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_idx,
  output logic [$clog2(NUM_REQ)-1:0] next_idx,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    // NOTE: outputs get defaults before the loop so no path leaves them
    // unassigned; a missing default here would infer a latch.
    next_idx = last_idx;
    found    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last_idx) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds whole messages from NUM_REQ byte sources
// into one UART byte transmitter. Define UART_ARB_TAG_EN to prefix each
// message with a one-byte owner tag ("A" + grant_id).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       stall_abort
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   grant_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic [STALL_W-1:0] stall_cnt, stall_nxt;
  logic [7:0]         data_arr [NUM_REQ];
  logic               own_valid;
  logic               own_last;
  logic [7:0]         own_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[8*g +: 8];
  end

  assign own_valid = req_valid[grant_id];
  assign own_last  = req_last[grant_id];
  assign own_data  = data_arr[grant_id];

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req      (req_valid),
    .last_idx (grant_id),
    .next_idx (pick_idx),
    .found    (pick_found)
  );

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_id;
    stall_nxt   = '0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    stall_abort = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          grant_nxt = pick_idx;
`ifdef UART_ARB_TAG_EN
          state_nxt = ST_TAG;
`else
          state_nxt = ST_XFER;
`endif
        end
      end

`ifdef UART_ARB_TAG_EN
      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = tag_byte(8'(grant_id));
        if (tx_ready) state_nxt = ST_XFER;
      end
`endif

      ST_XFER: begin
        tx_valid            = own_valid;
        tx_data             = own_data;
        req_ready[grant_id] = tx_ready;
        // A handshake always wins over the stall limit, so no accepted byte
        // is ever lost to a revocation in the same cycle.
        if (own_valid && tx_ready) begin
          if (own_last) state_nxt = ST_IDLE;
        end else if (stall_cnt == STALL_W'(STALL_LIMIT)) begin
          state_nxt   = ST_IDLE;
          stall_abort = 1'b1;
        end else begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_id  <= IDX_W'(NUM_REQ - 1);
      stall_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values computed above.
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      stall_cnt <= stall_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester messages, a
// message-level round-robin model, and a monitor checking every TX byte.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int STALL = 1023;
`ifdef UART_ARB_TAG_EN
  localparam int TAGN = 1;
`else
  localparam int TAGN = 0;
`endif

  typedef struct packed {
    logic       first;
    logic       last;
    logic [7:0] data;
  } ent_t;

  typedef struct packed {
    logic       tag;
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req_valid, req_last, req_ready;
  logic [8*NREQ-1:0] req_data;
  logic            tx_valid, tx_ready, busy, stall_abort;
  logic [7:0]      tx_data;
  logic [1:0]      grant_id;

  // Two stimulus sources: the queue-driven driver and direct manual drive.
  logic            drv_en;
  logic [NREQ-1:0] d_valid, d_last, m_valid, m_last;
  logic [8*NREQ-1:0] d_data, m_data;
  logic            d_ready, m_ready;
  logic            gap_en, abort_ok;
  int              rdy_mode;

  assign req_valid = drv_en ? d_valid : m_valid;
  assign req_data  = drv_en ? d_data  : m_data;
  assign req_last  = drv_en ? d_last  : m_last;
  assign tx_ready  = drv_en ? d_ready : m_ready;

  ent_t rq [NREQ][$];
  ent_t cp [NREQ][$];
  exp_t sb [$];
  int   model_last;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] b5 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

  uart_tx_arbiter #(.NUM_REQ(NREQ), .STALL_LIMIT(STALL)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .stall_abort (stall_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic first, input logic last);
    rq[r].push_back('{first, last, d});
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += rq[i].size();
    return s;
  endfunction

  // Message-level reference: whole messages go out in round-robin order of
  // the requesters that have one waiting, each optionally led by its tag.
  task automatic plan_expect();
    int   c;
    ent_t e;
    for (int i = 0; i < NREQ; i++) cp[i] = rq[i];
    while (1) begin
      c = -1;
      for (int off = 1; off <= NREQ; off++) begin
        int k;
        k = (model_last + off) % NREQ;
        if (c < 0 && cp[k].size() > 0) c = k;
      end
      if (c < 0) break;
      if (TAGN == 1) sb.push_back('{1'b1, 2'(c), 8'(8'h41 + c)});
      do begin
        e = cp[c].pop_front();
        sb.push_back('{1'b0, 2'(c), e.data});
      end while (!e.last);
      model_last = c;
    end
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while ((sb.size() != 0 || pending() != 0) && cyc < budget) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("drain_sb_left", 32'(sb.size()), 0);
    check("drain_rq_left", 32'(pending()), 0);
  endtask

  // Driver: retire accepted bytes, present queue heads (first bytes always
  // valid, later bytes with optional gaps), and pattern tx_ready.
  initial begin
    logic [NREQ-1:0] hs_mask;
    ent_t h;
    d_valid = '0;
    d_last  = '0;
    d_data  = '0;
    d_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs_mask = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (reset) begin
        d_valid = '0;
      end else begin
        if (drv_en)
          for (int i = 0; i < NREQ; i++)
            if (hs_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        for (int i = 0; i < NREQ; i++) begin
          if (rq[i].size() > 0) begin
            h = rq[i][0];
            d_valid[i] = h.first || !gap_en || ($urandom_range(3) != 0);
            d_data[8*i +: 8] = h.data;
            d_last[i] = h.last;
          end else begin
            d_valid[i] = 1'b0;
            d_last[i]  = 1'b0;
          end
        end
        case (rdy_mode)
          1:       d_ready = 1'($urandom_range(1));
          2:       d_ready = ~d_ready;
          default: d_ready = 1'b1;
        endcase
      end
    end
  end

  // Monitor: every TX handshake must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!abort_ok) check("stall_abort_quiet", {31'b0, stall_abort}, 0);
      if (tx_valid && !tx_ready) check("req_ready_gated", {28'b0, req_ready}, 0);
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %0h, want none at %0t", tx_data, $time);
        end else begin
          e = sb.pop_front();
          check("tx_data", {24'b0, tx_data}, {24'b0, e.data});
          check("grant_id", {30'b0, grant_id}, {30'b0, e.gid});
          check("req_ready", {28'b0, req_ready}, e.tag ? 32'd0 : (32'd1 << e.gid));
        end
      end
    end
  end

  initial begin
    int cyc, n, k;
    logic got;
    reset = 1'b1;
    drv_en = 1'b0;
    m_valid = '0;
    m_last = '0;
    m_data = '0;
    m_ready = 1'b0;
    gap_en = 1'b0;
    rdy_mode = 0;
    abort_ok = 1'b0;
    model_last = NREQ - 1;

    @(posedge clk);
    #1;
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_req_ready", {28'b0, req_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_stall_abort", {31'b0, stall_abort}, 0);
    check("rst_grant_id", {30'b0, grant_id}, NREQ - 1);
    @(posedge clk);
    #1 reset = 1'b0;

    // All four requesters with 2-byte messages, requester 0 twice.
    @(negedge clk);
    for (int r = 0; r < NREQ; r++) begin
      add_byte(r, 8'(8'hA0 + 2 * r), 1'b1, 1'b0);
      add_byte(r, 8'(8'hA1 + 2 * r), 1'b0, 1'b1);
    end
    add_byte(0, 8'hB0, 1'b1, 1'b0);
    add_byte(0, 8'hB1, 1'b0, 1'b1);
    plan_expect();
    drv_en = 1'b1;
    drain(200, cyc);
    check("rr_total_cycles", 32'(cyc), 32'(1 + 5 * (3 + TAGN)));

    // "Hi\r\n" from requester 2 with tx_ready toggling.
    @(negedge clk);
    rdy_mode = 2;
    add_byte(2, 8'h48, 1'b1, 1'b0);
    add_byte(2, 8'h69, 1'b0, 1'b0);
    add_byte(2, 8'h0D, 1'b0, 1'b0);
    add_byte(2, 8'h0A, 1'b0, 1'b1);
    plan_expect();
    drain(100, cyc);

    // "ok" from requester 1.
    @(negedge clk);
    rdy_mode = 0;
    add_byte(1, 8'h6F, 1'b1, 1'b0);
    add_byte(1, 8'h6B, 1'b0, 1'b1);
    plan_expect();
    drain(100, cyc);

    // Randomized rounds: random message mixes, valid gaps, random ready.
    gap_en = 1'b1;
    rdy_mode = 1;
    for (int round = 0; round < 10; round++) begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(1) == 1) begin
          int nm;
          nm = $urandom_range(3, 1);
          for (int m = 0; m < nm; m++) begin
            int len;
            len = $urandom_range(5, 1);
            for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), b == 0, b == len - 1);
          end
        end
      end
      if (pending() == 0) add_byte(round % NREQ, 8'h5A, 1'b1, 1'b1);
      plan_expect();
      drain(3000, cyc);
    end
    gap_en = 1'b0;
    rdy_mode = 0;

    // Stall revocation: requester 1 sends one byte then goes silent.
    @(posedge clk);
    #1;
    drv_en = 1'b0;
    m_ready = 1'b1;
    m_data = '0;
    m_data[15:8] = 8'h55;
    m_last = '0;
    m_valid = 4'b0010;
    if (TAGN == 1) sb.push_back('{1'b1, 2'd1, 8'h42});
    sb.push_back('{1'b0, 2'd1, 8'h55});
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && req_ready[1]) got = 1'b1;
    end
    check("stall_first_hs", {31'b0, got}, 1);
    @(posedge clk);
    #1;
    m_valid = 4'b1000;
    m_data[31:24] = 8'h77;
    m_last = 4'b1000;
    if (TAGN == 1) sb.push_back('{1'b1, 2'd3, 8'h44});
    sb.push_back('{1'b0, 2'd3, 8'h77});
    abort_ok = 1'b1;
    // Counter is 0 in the first silent cycle, so it equals the limit in
    // silent cycle STALL+1.
    n = 0;
    got = 1'b0;
    while (n < 2000 && !got) begin
      @(negedge clk);
      n++;
      if (stall_abort) got = 1'b1;
    end
    check("stall_abort_cycle", 32'(n), STALL + 1);
    check("stall_abort_grant", {30'b0, grant_id}, 1);
    @(negedge clk);
    check("stall_busy_after", {31'b0, busy}, 0);
    check("stall_abort_once", {31'b0, stall_abort}, 0);
    abort_ok = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && req_ready[3]) got = 1'b1;
    end
    check("stall_next_grant_hs", {31'b0, got}, 1);
    @(posedge clk);
    #1;
    m_valid = '0;
    m_last = '0;
    check("stall_sb_left", 32'(sb.size()), 0);

    // Reset during byte 3 of a 5-byte message from requester 0.
    if (TAGN == 1) sb.push_back('{1'b1, 2'd0, 8'h41});
    sb.push_back('{1'b0, 2'd0, b5[0]});
    sb.push_back('{1'b0, 2'd0, b5[1]});
    m_data = '0;
    m_data[7:0] = b5[0];
    m_valid = 4'b0001;
    k = 0;
    for (int t = 0; t < 30 && k < 2; t++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && req_ready[0]) begin
        k++;
        @(posedge clk);
        #1;
        m_data[7:0] = b5[k];
      end
    end
    check("rst_mid_bytes_sent", 32'(k), 2);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_mid_tx_data", {24'b0, tx_data}, 0);
    check("rst_mid_req_ready", {28'b0, req_ready}, 0);
    check("rst_mid_busy", {31'b0, busy}, 0);
    check("rst_mid_grant_id", {30'b0, grant_id}, NREQ - 1);
    check("rst_mid_sb_left", 32'(sb.size()), 0);
    m_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    model_last = NREQ - 1;

    // Fresh arbitration: lowest asserted index wins first.
    @(negedge clk);
    add_byte(3, 8'h33, 1'b1, 1'b0);
    add_byte(3, 8'h34, 1'b0, 1'b1);
    add_byte(1, 8'h31, 1'b1, 1'b1);
    plan_expect();
    drv_en = 1'b1;
    drain(100, cyc);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
